// File: rtl/space_invaders_pkg.sv
// Shared types and screen/bullet constants for the space invaders slice.
package space_invaders_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BULLET_STEP = 4;
  localparam int unsigned BULLET_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    COOL   = 2'd2
  } bullet_state_t;

  // Launch row sits LEN above the sprite, clamped to the top line.
  function automatic logic [9:0] launch_y(input logic [9:0] player_y, input logic [9:0] len);
    logic [9:0] y;
    if (player_y < len) begin
      y = 10'd0;
    end else begin
      y = player_y - len;
    end
    return y;
  endfunction

endpackage

// File: rtl/bullet_controller_edge_detect.sv
// 1-bit rising-edge detector: one history register, pulse valid while the input is newly high.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic prev_r;

  // Remember last cycle's level of the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sig;
    end
  end

  assign rise = sig & ~prev_r;

endmodule

// File: rtl/bullet_controller.sv
// Player bullet launch/flight/retire controller, one update per video frame.
// Optional retire cooldown enabled by defining BULLET_COOLDOWN_EN.
module bullet_controller
  import space_invaders_pkg::*;
#(
  parameter int unsigned STEP     = BULLET_STEP,
  parameter int unsigned LEN      = BULLET_LEN,
  parameter int unsigned X_OFFSET = 7,
  parameter int unsigned COOLDOWN = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] playerX,
  input  logic [9:0] playerY,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       hit,
  output logic       bullet_in,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic       bullet_active,
  output logic       kill
);

  localparam logic [9:0]  STEP_W  = 10'(STEP);
  localparam logic [9:0]  LEN_W   = 10'(LEN);
  localparam logic [10:0] LEN_X   = 11'(LEN);
  localparam logic [9:0]  X_OFF_W = 10'(X_OFFSET);

  logic          frame_tick_s;
  logic          fire_rise_s;
  logic          hit_any_s;
  bullet_state_t state_r, state_nxt_s;
  logic [9:0]    bullet_x_r, bullet_x_nxt_s;
  logic [9:0]    bullet_y_r, bullet_y_nxt_s;
  logic          fire_pend_r, fire_pend_nxt_s;
  logic          hit_lat_r, hit_lat_nxt_s;
  logic          kill_r, kill_nxt_s;
`ifdef BULLET_COOLDOWN_EN
  localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN - 1);
  logic [7:0]    cool_cnt_r, cool_cnt_nxt_s;
`endif

  edge_detect u_frame_edge (
    .clk   (Clk),
    .rst_n (Reset_n),
    .sig   (frame_clk),
    .rise  (frame_tick_s)
  );

  edge_detect u_fire_edge (
    .clk   (Clk),
    .rst_n (Reset_n),
    .sig   (fire),
    .rise  (fire_rise_s)
  );

  assign hit_any_s = hit_lat_r | hit;

  // Next-state and datapath decisions for the bullet FSM.
  always_comb begin
    state_nxt_s     = state_r;
    bullet_x_nxt_s  = bullet_x_r;
    bullet_y_nxt_s  = bullet_y_r;
    fire_pend_nxt_s = fire_pend_r;
    hit_lat_nxt_s   = hit_lat_r;
    kill_nxt_s      = 1'b0;
`ifdef BULLET_COOLDOWN_EN
    cool_cnt_nxt_s  = cool_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        // A fire edge coincident with the tick launches on that same tick.
        if (frame_tick_s && (fire_pend_r || fire_rise_s)) begin
          bullet_x_nxt_s  = playerX + X_OFF_W;
          bullet_y_nxt_s  = launch_y(playerY, LEN_W);
          fire_pend_nxt_s = 1'b0;
          hit_lat_nxt_s   = 1'b0;
          state_nxt_s     = FLYING;
        end else if (fire_rise_s) begin
          fire_pend_nxt_s = 1'b1;
        end else begin
          fire_pend_nxt_s = fire_pend_r;
        end
      end
      FLYING: begin
        if (frame_tick_s) begin
          hit_lat_nxt_s = 1'b0;
          if (hit_any_s || (bullet_y_r < STEP_W)) begin
            kill_nxt_s = hit_any_s;
`ifdef BULLET_COOLDOWN_EN
            cool_cnt_nxt_s = COOL_LOAD;
            state_nxt_s    = COOL;
`else
            state_nxt_s    = IDLE;
`endif
          end else begin
            bullet_y_nxt_s = bullet_y_r - STEP_W;
          end
        end else begin
          hit_lat_nxt_s = hit_any_s;
        end
      end
`ifdef BULLET_COOLDOWN_EN
      COOL: begin
        if (frame_tick_s) begin
          if (cool_cnt_r == 8'd0) begin
            state_nxt_s = IDLE;
          end else begin
            cool_cnt_nxt_s = cool_cnt_r - 8'd1;
          end
        end else begin
          cool_cnt_nxt_s = cool_cnt_r;
        end
      end
`endif
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and position registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= IDLE;
      bullet_x_r  <= 10'd0;
      bullet_y_r  <= 10'd0;
      fire_pend_r <= 1'b0;
      hit_lat_r   <= 1'b0;
      kill_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      bullet_x_r  <= bullet_x_nxt_s;
      bullet_y_r  <= bullet_y_nxt_s;
      fire_pend_r <= fire_pend_nxt_s;
      hit_lat_r   <= hit_lat_nxt_s;
      kill_r      <= kill_nxt_s;
    end
  end

`ifdef BULLET_COOLDOWN_EN
  // Cooldown frame counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cool_cnt_r <= 8'd0;
    end else begin
      cool_cnt_r <= cool_cnt_nxt_s;
    end
  end
`endif

  assign bullet_active = (state_r == FLYING);
  assign bulletX       = bullet_x_r;
  assign bulletY       = bullet_y_r;
  assign kill          = kill_r;

  // 11-bit bottom edge so a bullet near row 1023 cannot wrap the window.
  assign bullet_in = bullet_active && (DrawX == bullet_x_r) &&
                     ({1'b0, DrawY} >= {1'b0, bullet_y_r}) &&
                     ({1'b0, DrawY} < ({1'b0, bullet_y_r} + LEN_X));

endmodule

// File: tb/tb_bullet_controller.sv
// Directed self-checking bench for bullet_controller (handles BULLET_COOLDOWN_EN builds too).
module tb_bullet_controller;

  logic       Clk, Reset_n, frame_clk, fire, hit;
  logic [9:0] playerX, playerY, DrawX, DrawY;
  logic       bullet_in, bullet_active, kill;
  logic [9:0] bulletX, bulletY;
  logic       kill_obs, kill_after;
  int         tests_run, tests_failed;

  bullet_controller dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .fire          (fire),
    .playerX       (playerX),
    .playerY       (playerY),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .hit           (hit),
    .bullet_in     (bullet_in),
    .bulletX       (bulletX),
    .bulletY       (bulletY),
    .bullet_active (bullet_active),
    .kill          (kill)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fire_pulse();
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk) fire = 1'b0;
  endtask

  // One frame strobe; optionally assert hit in the tick cycle; capture kill around it.
  task automatic tick(input logic with_hit);
    @(negedge Clk);
    frame_clk = 1'b1;
    hit       = with_hit;
    @(negedge Clk);
    kill_obs  = kill;
    frame_clk = 1'b0;
    hit       = 1'b0;
    @(negedge Clk);
    kill_after = kill;
  endtask

  task automatic cooldown();
`ifdef BULLET_COOLDOWN_EN
    repeat (8) tick(1'b0);
`endif
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    Reset_n = 1'b0; frame_clk = 1'b0; fire = 1'b0; hit = 1'b0;
    playerX = 10'd300; playerY = 10'd440; DrawX = 10'd0; DrawY = 10'd0;
    kill_obs = 1'b0; kill_after = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_active", bullet_active, 0);
    check("rst_x", bulletX, 0);
    check("rst_y", bulletY, 0);
    check("rst_kill", kill, 0);
    check("rst_in", bullet_in, 0);
    Reset_n = 1'b1;
    @(negedge Clk);

    fire_pulse();
    tick(1'b0);
    check("launch_x", bulletX, 307);
    check("launch_y", bulletY, 436);
    check("launch_active", bullet_active, 1);

    repeat (10) tick(1'b0);
    check("flight_y", bulletY, 396);
    DrawX = 10'd307; DrawY = 10'd398; #1;
    check("in_mid", bullet_in, 1);
    DrawY = 10'd400; #1;
    check("in_below", bullet_in, 0);
    DrawY = 10'd396; #1;
    check("in_top", bullet_in, 1);
    DrawY = 10'd395; #1;
    check("in_above", bullet_in, 0);
    DrawX = 10'd308; DrawY = 10'd398; #1;
    check("in_col", bullet_in, 0);

    // Fire during flight must be dropped; then a mid-frame hit retires the bullet.
    fire_pulse();
    @(negedge Clk) hit = 1'b1;
    @(negedge Clk) hit = 1'b0;
    tick(1'b0);
    check("hit_kill", kill_obs, 1);
    check("hit_kill_1cyc", kill_after, 0);
    check("hit_active", bullet_active, 0);
    check("hit_y_hold", bulletY, 396);
`ifdef BULLET_COOLDOWN_EN
    for (int i = 0; i < 8; i++) begin
      fire_pulse();
      tick(1'b0);
      check("cool_ignore", bullet_active, 0);
    end
`else
    tick(1'b0);
    check("no_pend_from_flight", bullet_active, 0);
`endif
    fire_pulse();
    tick(1'b0);
    check("relaunch_active", bullet_active, 1);
    check("relaunch_y", bulletY, 436);

    tick(1'b1);
    check("simul_hit_kill", kill_obs, 1);
    check("simul_hit_active", bullet_active, 0);
    cooldown();

    playerY = 10'd10;
    fire_pulse();
    tick(1'b0);
    check("top_launch_y", bulletY, 6);
    tick(1'b0);
    check("top_step_y", bulletY, 2);
    tick(1'b0);
    check("top_retire_active", bullet_active, 0);
    check("top_retire_kill", kill_obs, 0);
    check("top_no_wrap", bulletY, 2);
    cooldown();

    playerY = 10'd2;
    fire_pulse();
    tick(1'b0);
    check("clamp_y", bulletY, 0);
    check("clamp_active", bullet_active, 1);
    tick(1'b0);
    check("clamp_retire", bullet_active, 0);
    cooldown();

    playerY = 10'd300;
    @(negedge Clk);
    fire = 1'b1; frame_clk = 1'b1;
    @(negedge Clk);
    fire = 1'b0; frame_clk = 1'b0;
    @(negedge Clk);
    check("simul_fire_active", bullet_active, 1);
    check("simul_fire_y", bulletY, 296);

    repeat (24) tick(1'b0);
    check("pre_rst_y", bulletY, 200);
    DrawX = 10'd307; DrawY = 10'd201; #1;
    check("pre_rst_in", bullet_in, 1);
    Reset_n = 1'b0; #1;
    check("async_rst_active", bullet_active, 0);
    check("async_rst_x", bulletX, 0);
    check("async_rst_y", bulletY, 0);
    check("async_rst_in", bullet_in, 0);
    @(negedge Clk) Reset_n = 1'b1;
    tick(1'b0);
    check("rst_pend_lost", bullet_active, 0);
    fire_pulse();
    tick(1'b0);
    check("post_rst_active", bullet_active, 1);
    check("post_rst_y", bulletY, 296);
    check("post_rst_x", bulletX, 307);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
